// File: rtl/sliding_window_generator.sv
// Raster-stream to KxK window generator: K-1 line buffers feed a shifting window register.
// Optional WINDOW_GEN_FRAME_COUNT_EN adds a 16-bit completed-frame counter output.
module sliding_window_generator #(
  parameter int unsigned C_SIGNAL_WIDTH     = 12,
  parameter int unsigned C_KERNEL_DIMENSION = 3,
  parameter int unsigned C_IMAGE_WIDTH      = 640,
  parameter int unsigned C_IMAGE_HEIGHT     = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [C_SIGNAL_WIDTH-1:0]     in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:C_KERNEL_DIMENSION-1][0:C_KERNEL_DIMENSION-1][C_SIGNAL_WIDTH-1:0] window_output,
  output logic                          out_last
`ifdef WINDOW_GEN_FRAME_COUNT_EN
  ,
  output logic [15:0]                   frame_count
`endif
);

  localparam int unsigned SW    = C_SIGNAL_WIDTH;
  localparam int unsigned K     = C_KERNEL_DIMENSION;
  localparam int unsigned W     = C_IMAGE_WIDTH;
  localparam int unsigned H     = C_IMAGE_HEIGHT;
  localparam int unsigned COL_W = $clog2(W);
  localparam int unsigned ROW_W = $clog2(H);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(H - 1);
  localparam logic [COL_W-1:0] COL_EMIT0 = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_EMIT0 = ROW_W'(K - 1);

  typedef logic [0:K-1][0:K-1][SW-1:0] win_t;
  typedef logic [0:K-1][SW-1:0]        colv_t;

  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_out_last, w_out_last_nxt;
  win_t             r_window, w_window_nxt;
  colv_t            w_col_vec;
  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_emit_pos;

  logic [SW-1:0] r_lb [0:K-2][0:W-1];

`ifdef WINDOW_GEN_FRAME_COUNT_EN
  logic [15:0] r_frame_count, w_frame_count_nxt;
  assign frame_count = r_frame_count;
`endif

  assign in_ready      = !r_out_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_col_last    = (r_col == COL_LAST);
  assign w_row_last    = (r_row == ROW_LAST);
  assign w_emit_pos    = (r_row >= ROW_EMIT0) && (r_col >= COL_EMIT0);

  assign out_valid     = r_out_valid;
  assign out_last      = r_out_last;
  assign window_output = r_window;

  // Column vector for the current position: buffered lines on top, live pixel at the bottom.
  always_comb begin
    w_col_vec = '0;
    for (int i = 0; i < int'(K) - 1; i++) begin
      w_col_vec[i] = r_lb[i][r_col];
    end
    w_col_vec[K-1] = in_pixel;
  end

  // Next-state for position counters, window register and output flags.
  always_comb begin
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_window_nxt    = r_window;
`ifdef WINDOW_GEN_FRAME_COUNT_EN
    w_frame_count_nxt = r_frame_count;
`endif
    if (w_accept) begin
      for (int i = 0; i < int'(K); i++) begin
        for (int j = 0; j < int'(K) - 1; j++) begin
          w_window_nxt[i][j] = r_window[i][j+1];
        end
        w_window_nxt[i][K-1] = w_col_vec[i];
      end
      w_out_valid_nxt = w_emit_pos;
      w_out_last_nxt  = w_emit_pos && w_col_last && w_row_last;
      if (w_col_last) begin
        w_col_nxt = '0;
        if (w_row_last) begin
          w_row_nxt = '0;
`ifdef WINDOW_GEN_FRAME_COUNT_EN
          w_frame_count_nxt = r_frame_count + 16'(1);
`endif
        end else begin
          w_row_nxt = r_row + ROW_W'(1);
        end
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end
    end else if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_window    <= '0;
`ifdef WINDOW_GEN_FRAME_COUNT_EN
      r_frame_count <= '0;
`endif
    end else begin
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_window    <= w_window_nxt;
`ifdef WINDOW_GEN_FRAME_COUNT_EN
      r_frame_count <= w_frame_count_nxt;
`endif
    end
  end

  // Line buffers are never cleared; row gating keeps stale lines out of emitted windows.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < int'(K) - 2; i++) begin
        r_lb[i][r_col] <= r_lb[i+1][r_col];
      end
      r_lb[K-2][r_col] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_sliding_window_generator.sv
// Bench for sliding_window_generator at W=8, H=6, K=3 against a frame-array reference model.
module tb_sliding_window_generator;

  localparam int unsigned SW = 12;
  localparam int unsigned K  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;

  typedef logic [0:K-1][0:K-1][SW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  win_t          window_output;
  logic          out_last;
`ifdef WINDOW_GEN_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  always #5 clk = ~clk;

  sliding_window_generator #(
    .C_SIGNAL_WIDTH    (SW),
    .C_KERNEL_DIMENSION(K),
    .C_IMAGE_WIDTH     (W),
    .C_IMAGE_HEIGHT    (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .window_output(window_output),
    .out_last     (out_last)
`ifdef WINDOW_GEN_FRAME_COUNT_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: the current frame as a 2-D image, plus a queue of windows still owed.
  logic [SW-1:0] img [0:H-1][0:W-1];
  win_t exp_q[$];
  bit   last_q[$];
  win_t seen[$];
  int   pos    = 0;
  int   frames = 0;
  int   pops   = 0;
  int   lasts  = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkw(input string tag, input win_t obs, input win_t exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [SW-1:0] px);
    int   r;
    int   c;
    win_t w;
    r = pos / int'(W);
    c = pos % int'(W);
    img[r][c] = px;
    if (r >= int'(K) - 1 && c >= int'(K) - 1) begin
      for (int i = 0; i < int'(K); i++)
        for (int j = 0; j < int'(K); j++)
          w[i][j] = img[r - int'(K) + 1 + i][c - int'(K) + 1 + j];
      exp_q.push_back(w);
      last_q.push_back(r == int'(H) - 1 && c == int'(W) - 1);
    end
    if (pos == int'(W * H) - 1) begin
      pos = 0;
      frames++;
    end else begin
      pos++;
    end
  endtask

  // One clock: drive at the falling edge, check #1 later, let the rising edge act.
  task automatic cycle(input logic v, input logic [SW-1:0] px, input logic rdy, output bit acc);
    bit mdl_ready;
    in_valid  = v;
    in_pixel  = px;
    out_ready = rdy;
    #1;
    mdl_ready = (exp_q.size() == 0) || rdy;
    acc       = v && mdl_ready;
    chk1("out_valid", out_valid, exp_q.size() != 0);
    chk1("in_ready", in_ready, mdl_ready);
`ifdef WINDOW_GEN_FRAME_COUNT_EN
    chkn("frame_count", int'(frame_count), frames % 65536);
`endif
    if (exp_q.size() != 0) begin
      chkw("window", window_output, exp_q[0]);
      chk1("out_last", out_last, last_q[0]);
      if (rdy) begin
        seen.push_back(exp_q[0]);
        if (last_q[0]) lasts++;
        pops++;
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
    end
    if (acc) model_accept(px);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send n accepted pixels; pattern mode uses value = r*8+c of the model's next position.
  task automatic send(input int n, input bit pattern, input int vpct, input int rpct);
    int            k;
    int            budget;
    bit            acc;
    logic          v;
    logic          rdy;
    logic [SW-1:0] px;
    k      = 0;
    budget = 0;
    while (k < n && budget < 4000) begin
      v   = ($urandom_range(0, 99) < vpct);
      rdy = ($urandom_range(0, 99) < rpct);
      px  = pattern ? SW'(pos) : SW'($urandom);
      cycle(v, px, rdy, acc);
      if (acc) k++;
      budget++;
    end
    chkn("send_budget", k, n);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chkw("rst_window", window_output, '0);
    chk1("rst_in_ready", in_ready, 1'b1);
`ifdef WINDOW_GEN_FRAME_COUNT_EN
    chkn("rst_frame_count", int'(frame_count), 0);
`endif
    exp_q.delete();
    last_q.delete();
    pos    = 0;
    frames = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit   acc;
    win_t w_first;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    #2;
    do_reset();

    // Full pattern frame at full rate.
    pops = 0; lasts = 0; seen.delete();
    send(W * H, 1'b1, 100, 100);
    drain();
    chkn("frame_windows", pops, 24);
    chkn("frame_lasts", lasts, 1);
    w_first = seen[0];
    chkn("first_00", int'(w_first[0][0]), 0);
    chkn("first_11", int'(w_first[1][1]), 9);
    chkn("first_22", int'(w_first[2][2]), 18);
    chkn("last_00", int'(seen[23][0][0]), 29);
    chkn("last_22", int'(seen[23][2][2]), 47);

    // Backpressure: stall 5 cycles right after the first window appears.
    do_reset();
    pops = 0; lasts = 0; seen.delete();
    send(19, 1'b1, 100, 100);
    for (int i = 0; i < 5; i++) cycle(1'b1, SW'(pos), 1'b0, acc);
    send(W * H - 19, 1'b1, 100, 100);
    drain();
    chkn("bp_windows", pops, 24);
    chkn("bp_lasts", lasts, 1);

    // Back-to-back frames.
    do_reset();
    pops = 0; lasts = 0; seen.delete();
    send(2 * W * H, 1'b1, 100, 100);
    drain();
    chkn("b2b_windows", pops, 48);
    chkn("b2b_lasts", lasts, 2);
    chkw("b2b_win25", seen[24], seen[0]);

    // Reset in the middle of a frame with a window pending.
    send(31, 1'b1, 100, 100);
    rst = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    do_reset();
    pops = 0; lasts = 0; seen.delete();
    send(W * H, 1'b1, 100, 100);
    drain();
    chkn("restart_22", int'(seen[0][2][2]), 18);
    chkn("restart_00", int'(seen[0][0][0]), 0);
    chkn("restart_windows", pops, 24);

    // Random pixels with random valid/ready over several frames.
    pops = 0; lasts = 0; seen.delete();
    send(4 * W * H, 1'b0, 70, 60);
    drain();
    chkn("rand_windows", pops, 96);
    chkn("rand_lasts", lasts, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
